// File: rtl/hilo_unit_pkg.sv
// Shared HI/LO definitions: FSM state encodings and default sizing.
// Latency: n/a (constants only).
// Backpressure: n/a.
package hilo_unit_pkg;

  // Default datapath width and radix-2 divide iteration count
  localparam int HILO_WIDTH_DEF    = 32;
  localparam int HILO_DIV_ITER_DEF = 32;

  // HI/LO control FSM state encodings
  localparam logic [1:0] HILO_IDLE     = 2'd0;
  localparam logic [1:0] HILO_DIV_RUN  = 2'd1;
  localparam logic [1:0] HILO_DIV_DONE = 2'd2;

endpackage

// File: rtl/hilo_unit_div_radix2.sv
// Restoring radix-2 unsigned divider on magnitudes; one quotient bit per cycle.
// Latency: DIV_ITER cycles after start; done and results are combinational in the last one.
// Backpressure: none; abort drops an in-flight divide at the next edge.
//
// Ports:
//   clk, resetn          clock, async active-low reset
//   start                latch dividend/divisor and begin iterating
//   abort                abandon the running divide
//   dividend, divisor    unsigned magnitudes
//   quotient, remainder  unsigned results, valid while done=1
//   done                 high during the final iteration cycle
module hilo_unit_div_radix2
  import hilo_unit_pkg::*;
#(
  parameter int WIDTH    = HILO_WIDTH_DEF,
  parameter int DIV_ITER = HILO_DIV_ITER_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CW = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_ITER - 1);

  logic [WIDTH-1:0] q_r;    // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_r;    // partial remainder
  logic [WIDTH-1:0] d_r;    // divisor
  logic [CW-1:0]    cnt_r;
  logic             run_r;

  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] r_nx;
  logic [WIDTH-1:0] q_nx;

  // Trial value is one bit wider than the remainder so a divisor with its
  // MSB set still compares correctly; the restored result always fits WIDTH.
  always_comb begin
    trial = {r_r, q_r[WIDTH-1]};
    ge    = (trial >= {1'b0, d_r});
    r_nx  = ge ? (trial[WIDTH-1:0] - d_r) : trial[WIDTH-1:0];
    q_nx  = {q_r[WIDTH-2:0], ge};
  end

  assign done      = run_r && (cnt_r == LAST);
  assign quotient  = q_nx;
  assign remainder = r_nx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_r   <= '0;
      r_r   <= '0;
      d_r   <= '0;
      cnt_r <= '0;
      run_r <= 1'b0;
    end else if (abort) begin
      run_r <= 1'b0;
      cnt_r <= '0;
    end else if (start) begin
      q_r   <= dividend;
      r_r   <= '0;
      d_r   <= divisor;
      cnt_r <= '0;
      run_r <= 1'b1;
    end else if (run_r) begin
      q_r <= q_nx;
      r_r <= r_nx;
      if (done) begin
        run_r <= 1'b0;
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// Execute-stage HI/LO block: MTHI/MTLO, MFHI/MFLO, 1-cycle MULT(U), iterative DIV(U).
// Latency: MT/MULT write at the next edge; DIV writes after 1 + DIV_ITER stalled cycles.
// Backpressure: stall is raised combinationally in the divide start cycle and held while running.
//
// Ports:
//   clk, resetn            clock, async active-low reset
//   flush                  kill the execute instruction (aborts a running divide)
//   hilowrite/hilodst      MT request, 1 = HI, 0 = LO; data on wdata
//   hiloToReg/hilosrc      MF read qualifier and HI/LO select for hilo_rdata
//   mult_start/div_start   issue MULT(U) / DIV(U); is_signed selects the variant
//   src_a, src_b           rs / rt operands
//   hilo_rdata             selected register, 0 when not reading
//   hi_o, lo_o             registered HI and LO
//   stall, busy            pipeline freeze / divider running
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int WIDTH    = HILO_WIDTH_DEF,
  parameter int DIV_ITER = HILO_DIV_ITER_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             hilowrite,
  input  logic             hilodst,
  input  logic             hiloToReg,
  input  logic             hilosrc,
  input  logic [WIDTH-1:0] wdata,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             stall,
  output logic             busy
);

  logic [1:0]       state_r;
  logic [1:0]       state_nx;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  // Sign-correction context captured when the divide starts
  logic             neg_q_r;
  logic             neg_r_r;
  logic             dbz_r;
  logic [WIDTH-1:0] a_raw_r;

  logic             accept;
  logic             div_go;
  logic             mult_go;
  logic             mt_go;
  logic             div_commit;
  logic             div_abort;
  logic             running;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic             div_done;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign running = (state_r == HILO_DIV_RUN);

  // New requests are taken in IDLE and DIV_DONE; a flushed instruction does nothing.
  // Priority: divide over multiply over MT write.
  assign accept  = !running && !flush;
  assign div_go  = accept && div_start;
  assign mult_go = accept && mult_start && !div_start;
  assign mt_go   = accept && hilowrite && !div_start && !mult_start;

  // A flush arriving in the last iteration still wins: nothing is committed.
  assign div_abort  = running && flush;
  assign div_commit = running && div_done && !flush;

  assign stall = running || div_go;
  assign busy  = running;

  // Operand magnitudes for the unsigned divider core
  always_comb begin
    a_mag = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    b_mag = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;
  end

  // Full-width product: extend both operands to 2*WIDTH so the truncated
  // product is exact for both signed and unsigned interpretations.
  always_comb begin
    a_ext = is_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
    b_ext = is_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
    prod  = a_ext * b_ext;
  end

  hilo_unit_div_radix2 #(
    .WIDTH    (WIDTH),
    .DIV_ITER (DIV_ITER)
  ) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_go),
    .abort     (div_abort),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (q_mag),
    .remainder (r_mag),
    .done      (div_done)
  );

  // Divide by zero bypasses sign correction: LO all ones, HI the raw dividend.
  // The most-negative / -1 case needs no special handling: its magnitude
  // quotient negates back onto itself.
  always_comb begin
    if (dbz_r) begin
      q_fix = '1;
      r_fix = a_raw_r;
    end else begin
      q_fix = neg_q_r ? -q_mag : q_mag;
      r_fix = neg_r_r ? -r_mag : r_mag;
    end
  end

  always_comb begin
    state_nx = state_r;
    case (state_r)
      HILO_IDLE, HILO_DIV_DONE: state_nx = div_go ? HILO_DIV_RUN : HILO_IDLE;
      HILO_DIV_RUN: begin
        if (flush)         state_nx = HILO_IDLE;
        else if (div_done) state_nx = HILO_DIV_DONE;
        else               state_nx = HILO_DIV_RUN;
      end
      default:             state_nx = HILO_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= HILO_IDLE;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      dbz_r   <= 1'b0;
      a_raw_r <= '0;
    end else begin
      state_r <= state_nx;
      if (div_go) begin
        neg_q_r <= is_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        neg_r_r <= is_signed && src_a[WIDTH-1];
        dbz_r   <= (src_b == '0);
        a_raw_r <= src_a;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (div_commit) begin
      lo_r <= q_fix;
      hi_r <= r_fix;
    end else if (mult_go) begin
      hi_r <= prod[2*WIDTH-1:WIDTH];
      lo_r <= prod[WIDTH-1:0];
    end else if (mt_go) begin
      if (hilodst) hi_r <= wdata;
      else         lo_r <= wdata;
    end
  end

  // No same-cycle bypass: reads see the registered values only
  assign hilo_rdata = hiloToReg ? (hilosrc ? hi_r : lo_r) : '0;
  assign hi_o       = hi_r;
  assign lo_o       = lo_r;

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Execute-stage HI/LO register block. It consumes the HI/LO control bits that the main decoder produces: hilowrite, hilodst, hiloToReg, hilosrc.
- Performs MTHI/MTLO writes, MFHI/MFLO reads, single-cycle MULT/MULTU and iterative DIV/DIVU.
- Raises a stall to the hazard unit while a divide is in flight.

Parameters:
- WIDTH, 32, datapath width; HI and LO are each WIDTH bits.
- DIV_ITER, WIDTH, radix-2 iterations per divide.

Ports:
- clk  in  1  core clock, rising edge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  exception/branch flush of the execute instruction
- hilowrite  in  1  MTHI/MTLO write request
- hilodst  in  1  1 = write HI, 0 = write LO
- hiloToReg  in  1  MFHI/MFLO read in progress; qualifies hilo_rdata
- hilosrc  in  1  1 = read HI, 0 = read LO
- wdata  in  WIDTH  rs value for MTHI/MTLO
- mult_start  in  1  MULT/MULTU issued
- div_start  in  1  DIV/DIVU issued
- is_signed  in  1  signed variant of mult/div
- src_a  in  WIDTH  rs operand (dividend / multiplicand)
- src_b  in  WIDTH  rt operand (divisor / multiplier)
- hilo_rdata  out  WIDTH  selected HI or LO; 0 when hiloToReg=0
- hi_o  out  WIDTH  current HI
- lo_o  out  WIDTH  current LO
- stall  out  1  freeze pipeline
- busy  out  1  divider running

Behaviour:
- Reset (async, resetn=0):
  - HI=LO=0, state IDLE, stall=busy=0, hilo_rdata=0.
  - Reset mid-divide abandons the divide immediately.
- States: IDLE, DIV_RUN, DIV_DONE.
- IDLE, requests accepted only when flush=0. Priority is div_start > mult_start > hilowrite.
- MTHI/MTLO: with hilowrite=1, wdata is written to HI (hilodst=1) or LO (hilodst=0) at the next edge. The other register is unchanged.
- MULT/MULTU: the full 2*WIDTH product of src_a and src_b (signed or unsigned per is_signed) is written {HI,LO} at the next edge. Latency 1, no stall.
- DIV/DIVU:
  - In the start cycle, stall=1 combinationally. Operands are latched, converted to magnitudes if signed, and the state moves to DIV_RUN.
  - DIV_RUN: one restoring iteration per cycle with an iteration counter 0..DIV_ITER-1, stall=busy=1.
  - After the last iteration, the next edge writes LO=quotient, HI=remainder and the state moves to DIV_DONE.
  - DIV_DONE: stall=busy=0 for one cycle, then the state returns to IDLE. A new start request is accepted in DIV_DONE.
  - Total stall is 1 + DIV_ITER cycles (33 at default).
- Signed division:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero: full latency. LO=all-ones, HI=src_a unchanged in bit pattern, for both signed and unsigned.
- Starts and hilowrite during DIV_RUN are ignored. The hazard unit holds them via stall.
- flush:
  - In IDLE it suppresses all writes that cycle.
  - In DIV_RUN the state goes to IDLE at the next edge, stall and busy go to 0 the cycle after flush, and HI/LO are unchanged.
  - flush in DIV_DONE has no effect; the result is already committed.
- Read path: hilo_rdata = hiloToReg ? (hilosrc ? HI : LO) : 0, combinational from registered values. There is no same-cycle bypass; the forwarding unit handles an MT followed by MF.
- hi_o and lo_o always reflect the registered values.

Decomposition:
- Shared defines header (alongside the opcode/funct defines):
  - state encodings HILO_IDLE, HILO_DIV_RUN, HILO_DIV_DONE
  - default DIV_ITER
- Sub-module div_radix2:
  - inputs: start, abort, dividend/divisor magnitudes
  - outputs: quotient magnitude, remainder magnitude, done
  - it owns the iteration counter
- hilo_unit keeps the FSM, sign correction, the HI/LO registers and the read mux.

Test Plan:
- Reset then MTHI wdata=0x12345678, MTLO wdata=0x9ABCDEF0 -> HI=0x12345678, LO=0x9ABCDEF0; MFHI gives hilo_rdata=0x12345678, MFLO gives 0x9ABCDEF0.
- MULT signed src_a=0xFFFFFFFE (-2), src_b=3 -> next edge HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with same operands -> HI=0x00000002, LO=0xFFFFFFFA; stall never asserted.
- DIVU 100/7 -> stall high exactly 33 cycles, then LO=14, HI=2; DIV signed -100/7 -> LO=0xFFFFFFF2, HI=0xFFFFFFFE.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 5/0 -> LO=0xFFFFFFFF, HI=5 after 33 stall cycles.
- Flush at iteration 10 of DIVU 100/7 with prior HI=LO=0x11111111 -> stall drops the following cycle, HI/LO stay 0x11111111; a subsequent mult_start is accepted.
- Assert resetn=0 mid-divide -> HI=LO=0, stall=busy=0 immediately; simultaneous div_start+hilowrite in IDLE -> divide runs, MT write dropped.
